gcd_controller: RTL and testbench
=================================

# gcd_controller

Control FSM for the 4-bit subtractive GCD FSMD. Drives the datapath's register-load and mux-select strobes and consumes its `x_neq_y` / `x_lt_y` status flags. Exposes a start/busy/done handshake to the surrounding logic and an iteration count. An optional watchdog aborts runs that do not converge, such as a zero operand.

## Interface
Parameters:
- `ITER_W`, default 5: width of the iteration counter.
- `MAX_ITER`, default 16: iteration limit for the watchdog. Only used when `GCD_TIMEOUT_EN` is defined. Must satisfy MAX_ITER < 2^ITER_W.

Ports:
- `CLK`  in  1  single system clock; all state changes on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin a GCD run; sampled only in IDLE.
- `x_neq_y`  in  1  datapath flag: x register ≠ y register.
- `x_lt_y`  in  1  datapath flag: x register < y register.
- `x_sel`  out  1  0 = load x from `x_i`; 1 = load x − y.
- `x_ld`  out  1  x register load enable.
- `y_sel`  out  1  0 = load y from `y_i`; 1 = load y − x.
- `y_ld`  out  1  y register load enable.
- `d_ld`  out  1  result register load enable (d ← x).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse marking the end of a run.
- `err`  out  1  one-cycle pulse, coincident with `done`, on watchdog abort.
- `iter_o`  out  ITER_W  count of subtract steps in the current or last run.

## Operation
- States: IDLE, LOAD, CMP, SUBX, SUBY, STORE, DONE, and ERR (ERR exists only with the macro defined).
- All strobes are Moore outputs, decoded from the current state only. A strobe not listed for a state is 0 in that state.
- IDLE:
  - `start`=1 → LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Outputs: `x_ld`=`y_ld`=1, `x_sel`=`y_sel`=0.
  - `iter_o` clears to 0.
  - Next state: CMP.
- CMP (no strobes):
  - `x_neq_y`=0 → STORE.
  - Else `x_lt_y`=1 → SUBY.
  - Else → SUBX.
- SUBX:
  - Outputs: `x_sel`=1, `x_ld`=1.
  - `iter_o` increments.
  - Next state: CMP.
- SUBY:
  - Outputs: `y_sel`=1, `y_ld`=1.
  - `iter_o` increments.
  - Next state: CMP.
- STORE: `d_ld`=1; next state DONE.
- DONE: `done`=1; next state IDLE.
- `iter_o` saturates at all-ones and never wraps. It holds its final value in IDLE until the next LOAD.
- `start` is ignored in every state other than IDLE; it has no effect while `busy`=1.
- An operand of 0 never converges; the controller cannot see the data. With the macro undefined, the FSM loops between CMP and SUBX/SUBY until reset.

## Timing
- Reset (`RESET`=0, asynchronous):
  - State goes to IDLE.
  - All strobes, `busy`, `done`, `err` go to 0.
  - `iter_o` goes to 0.
  - This applies at any point, including mid-run. The datapath contents are not affected.
- Let `start` be sampled high at edge 0:
  - LOAD is cycle 1 and the first CMP is cycle 2.
  - After k subtract steps, the CMP occurs in cycle 2+2k.
  - A convergent run with N steps has STORE in cycle 3+2N and DONE (`done`=1) in cycle 4+2N.
- `d_o` is valid from the cycle after STORE, i.e. it is valid while `done`=1.
- Back-to-back runs: `start` held high during DONE is not seen. The earliest next LOAD is 2 cycles after DONE: one IDLE cycle, then LOAD.

## Configuration
- Macro `GCD_TIMEOUT_EN`.
- Defined:
  - In CMP with `x_neq_y`=1 and `iter_o`==MAX_ITER, the next state is ERR.
  - ERR drives `done`=1 and `err`=1 for one cycle, with no `d_ld`, then returns to IDLE.
  - `iter_o` reads MAX_ITER.
- Undefined:
  - No ERR state; `err` is tied to 0.
  - Zero operands hang until reset.

## Test plan
- x_i=8, y_i=12, `start` pulse:
  - Sequence LOAD, CMP, SUBY, CMP, SUBX, CMP, STORE, DONE.
  - `done` in cycle 8, `iter_o`=2, `d_o`=4.
- x_i=7, y_i=7:
  - No subtract strobes.
  - `done` in cycle 4, `iter_o`=0, `d_o`=7.
- x_i=1, y_i=15:
  - 14 SUBY steps.
  - `done` in cycle 32, `iter_o`=14, `d_o`=1, `err`=0.
- x_i=15, y_i=6, with `start` re-pulsed while `busy`=1:
  - The extra `start` is ignored.
  - `done` in cycle 10, `iter_o`=3, `d_o`=3.
- `RESET` low during SUBX of the 8/12 run:
  - Immediate IDLE; all outputs and `iter_o` read 0.
  - A fresh `start` then reruns to completion (`d_o`=4).
- `GCD_TIMEOUT_EN` defined, x_i=0, y_i=5:
  - ERR in cycle 35 with `done`=`err`=1.
  - `d_ld` never asserted, `iter_o`=16, back in IDLE in cycle 36.

Source files
------------

// File: rtl/gcd_controller.sv
// -----------------------------------------------------------------------------
// gcd_controller
//
// Control FSM for a 4-bit subtractive GCD FSMD. It sequences the datapath
// register loads and mux selects from the datapath's equality / less-than
// flags, reports progress through a start/busy/done handshake and counts the
// subtract steps of each run.
//
// Optional feature (compile-time macro GCD_TIMEOUT_EN):
//   defined   - watchdog: a run that reaches MAX_ITER subtract steps without
//               converging is aborted through the ERR state (done+err pulse).
//   undefined - no ERR state, err is tied low; a zero operand loops until
//               reset.
//
// Parameters:
//   ITER_W    width of the iteration counter (default 5)
//   MAX_ITER  watchdog limit, used only with GCD_TIMEOUT_EN (default 16);
//             must be < 2**ITER_W
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous active-low reset
//   start    in   run request, sampled only in IDLE
//   x_neq_y  in   datapath flag: x != y
//   x_lt_y   in   datapath flag: x < y
//   x_sel    out  x mux select (0: x_i, 1: x - y)
//   x_ld     out  x register load enable
//   y_sel    out  y mux select (0: y_i, 1: y - x)
//   y_ld     out  y register load enable
//   d_ld     out  result register load enable (d <- x)
//   busy     out  high in every state except IDLE
//   done     out  one-cycle end-of-run pulse
//   err      out  one-cycle watchdog-abort pulse, coincident with done
//   iter_o   out  subtract-step count of the current or last run
// -----------------------------------------------------------------------------
module gcd_controller #(
    parameter int ITER_W   = 5,
    parameter int MAX_ITER = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              x_neq_y,
    input  logic              x_lt_y,
    output logic              x_sel,
    output logic              x_ld,
    output logic              y_sel,
    output logic              y_ld,
    output logic              d_ld,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_o
);

    // Elaboration-time sanity check of the watchdog limit.
    if (MAX_ITER >= (1 << ITER_W)) begin : g_bad_max_iter
        $error("gcd_controller: MAX_ITER must be smaller than 2**ITER_W");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CMP   = 3'd2,
        S_SUBX  = 3'd3,
        S_SUBY  = 3'd4,
        S_STORE = 3'd5,
        S_DONE  = 3'd6
`ifdef GCD_TIMEOUT_EN
        ,
        S_ERR   = 3'd7
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_q,  iter_d;

`ifdef GCD_TIMEOUT_EN
    localparam logic [ITER_W-1:0] MaxIterV = MAX_ITER[ITER_W-1:0];
`endif

    // -------------------------------------------------------------------------
    // State and iteration counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_CMP;
            S_CMP: begin
                if (!x_neq_y) begin
                    state_d = S_STORE;
`ifdef GCD_TIMEOUT_EN
                end else if (iter_q == MaxIterV) begin
                    // Watchdog takes priority over another subtract step.
                    state_d = S_ERR;
`endif
                end else if (x_lt_y) begin
                    state_d = S_SUBY;
                end else begin
                    state_d = S_SUBX;
                end
            end
            S_SUBX:  state_d = S_CMP;
            S_SUBY:  state_d = S_CMP;
            S_STORE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
`ifdef GCD_TIMEOUT_EN
            S_ERR:   state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Iteration counter: cleared by LOAD, +1 per subtract step, saturating.
    // The value therefore holds through DONE/IDLE until the next LOAD.
    // -------------------------------------------------------------------------
    always_comb begin
        iter_d = iter_q;
        if (state_q == S_LOAD) begin
            iter_d = '0;
        end else if ((state_q == S_SUBX) || (state_q == S_SUBY)) begin
            if (iter_q != '1) begin
                iter_d = iter_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        x_sel = 1'b0;
        x_ld  = 1'b0;
        y_sel = 1'b0;
        y_ld  = 1'b0;
        d_ld  = 1'b0;
        busy  = (state_q != S_IDLE);
        done  = 1'b0;
        err   = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                x_ld = 1'b1;
                y_ld = 1'b1;
            end
            S_SUBX: begin
                x_sel = 1'b1;
                x_ld  = 1'b1;
            end
            S_SUBY: begin
                y_sel = 1'b1;
                y_ld  = 1'b1;
            end
            S_STORE: d_ld = 1'b1;
            S_DONE:  done = 1'b1;
`ifdef GCD_TIMEOUT_EN
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign iter_o = iter_q;

    // -------------------------------------------------------------------------
    // Properties
    // -------------------------------------------------------------------------
    a_err_with_done : assert property (@(posedge CLK) disable iff (!RESET)
        err |-> done);
    a_no_store_on_done : assert property (@(posedge CLK) disable iff (!RESET)
        done |-> !d_ld);

endmodule

// File: tb/tb_gcd_controller.sv
// -----------------------------------------------------------------------------
// tb_gcd_controller
//
// Bench for gcd_controller. A small 4-bit datapath (x, y, d registers) is
// modelled here and driven by the controller strobes; it feeds the status
// flags back. Expected results come from plain arithmetic (Euclid via modulo
// for the GCD, a subtraction count for the step number, 4+2N for the done
// cycle). Cycle c is the cycle after edge c, where edge 0 samples start.
// -----------------------------------------------------------------------------
module tb_gcd_controller;

    localparam int ITER_W   = 5;
    localparam int MAX_ITER = 16;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              start = 1'b0;
    logic              x_neq_y, x_lt_y;
    logic              x_sel, x_ld, y_sel, y_ld, d_ld, busy, done, err;
    logic [ITER_W-1:0] iter_o;

    logic [3:0] x_i = '0, y_i = '0;
    logic [3:0] x_q = '0, y_q = '0, d_q = '0;

    int checks = 0;
    int errors = 0;

    gcd_controller #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .start   (start),
        .x_neq_y (x_neq_y),
        .x_lt_y  (x_lt_y),
        .x_sel   (x_sel),
        .x_ld    (x_ld),
        .y_sel   (y_sel),
        .y_ld    (y_ld),
        .d_ld    (d_ld),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .iter_o  (iter_o)
    );

    always #5 CLK = ~CLK;

    // Datapath model controlled by the DUT strobes.
    always @(posedge CLK) begin
        if (x_ld) x_q <= x_sel ? (x_q - y_q) : x_i;
        if (y_ld) y_q <= y_sel ? (y_q - x_q) : y_i;
        if (d_ld) d_q <= x_q;
    end
    assign x_neq_y = (x_q != y_q);
    assign x_lt_y  = (x_q <  y_q);

    // ---------------------------------------------------------------- model
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int ref_steps(input int a, input int b);
        int n = 0;
        while (a != b) begin
            if (a < b) b = b - a; else a = a - b;
            n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One run from a start pulse; observes once per cycle at the falling edge.
    task automatic do_run(input logic [3:0] xv, input logic [3:0] yv,
                          input bit repulse, input int budget,
                          output int done_cyc, output int iter_v,
                          output int d_v, output int err_v,
                          output int dld_cnt, output int dld_cyc,
                          output int sub_cnt, output int load_ok);
        int cyc;
        done_cyc = -1; iter_v = -1; d_v = -1; err_v = -1;
        dld_cnt = 0; dld_cyc = -1; sub_cnt = 0; load_ok = 0;
        @(negedge CLK);
        x_i = xv; y_i = yv; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        cyc = 1;
        while (cyc <= budget) begin
            if (cyc == 1)
                load_ok = int'(x_ld && y_ld && !x_sel && !y_sel && busy && !done);
            if (d_ld) begin dld_cnt++; dld_cyc = cyc; end
            if ((x_ld && x_sel) || (y_ld && y_sel)) sub_cnt++;
            if (repulse && cyc == 3) start = 1'b1;
            if (repulse && cyc == 4) start = 1'b0;
            if (done) begin
                done_cyc = cyc; iter_v = int'(iter_o);
                d_v = int'(d_q); err_v = int'(err);
                break;
            end
            @(negedge CLK);
            cyc++;
        end
    endtask

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        bit         repulse;
        int         exp_d;
        int         exp_iter;
        int         exp_cyc;
    } vec_t;

    initial begin : main
        vec_t vecs[4];
        int dc, it, dv, ev, dn, dcy, sc, lo, n, g, cyc;
        logic [3:0] rx, ry;

        vecs[0] = '{4'd8,  4'd12, 1'b0, 4, 2,  8};
        vecs[1] = '{4'd7,  4'd7,  1'b0, 7, 0,  4};
        vecs[2] = '{4'd1,  4'd15, 1'b0, 1, 14, 32};
        vecs[3] = '{4'd15, 4'd6,  1'b1, 3, 3,  10};

        // Reset state
        #1 RESET = 1'b0;
        #2;
        check("reset_busy", int'(busy), 0);
        check("reset_strobes", int'({x_sel, x_ld, y_sel, y_ld, d_ld, done, err}), 0);
        check("reset_iter", int'(iter_o), 0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_no_start", int'(busy), 0);

        // Directed table
        foreach (vecs[i]) begin
            do_run(vecs[i].x, vecs[i].y, vecs[i].repulse, 100,
                   dc, it, dv, ev, dn, dcy, sc, lo);
            check($sformatf("t%0d_done_cyc", i), dc, vecs[i].exp_cyc);
            check($sformatf("t%0d_iter", i), it, vecs[i].exp_iter);
            check($sformatf("t%0d_d", i), dv, vecs[i].exp_d);
            check($sformatf("t%0d_err", i), ev, 0);
            check($sformatf("t%0d_dld_cnt", i), dn, 1);
            check($sformatf("t%0d_dld_cyc", i), dcy, vecs[i].exp_cyc - 1);
            check($sformatf("t%0d_subs", i), sc, vecs[i].exp_iter);
            check($sformatf("t%0d_load", i), lo, 1);
            @(negedge CLK);
            check($sformatf("t%0d_idle_after", i), int'(busy), 0);
            check($sformatf("t%0d_iter_hold", i), int'(iter_o), vecs[i].exp_iter);
        end

        // Randomized nonzero operands against the arithmetic model
        for (int r = 0; r < 20; r++) begin
            rx = 4'($urandom_range(1, 15));
            ry = 4'($urandom_range(1, 15));
            g  = ref_gcd(int'(rx), int'(ry));
            n  = ref_steps(int'(rx), int'(ry));
            do_run(rx, ry, 1'($urandom_range(0, 1)), 100,
                   dc, it, dv, ev, dn, dcy, sc, lo);
            check($sformatf("r%0d_%0d_%0d_d", r, rx, ry), dv, g);
            check($sformatf("r%0d_%0d_%0d_iter", r, rx, ry), it, n);
            check($sformatf("r%0d_%0d_%0d_cyc", r, rx, ry), dc, 4 + 2 * n);
            check($sformatf("r%0d_%0d_%0d_err", r, rx, ry), ev, 0);
        end

        // Back-to-back: start held high through DONE is not seen
        @(negedge CLK);
        x_i = 4'd8; y_i = 4'd12; start = 1'b1;
        @(posedge CLK);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!done && cyc < 100);
        check("b2b_done_cyc", cyc, 8);
        @(negedge CLK);
        check("b2b_idle_gap", int'(busy), 0);
        @(negedge CLK);
        check("b2b_reload", int'(busy && x_ld && y_ld), 1);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        check("b2b_second_d", int'(d_q), 4);

        // Asynchronous reset during SUBX of the 8/12 run, then rerun
        @(negedge CLK);
        x_i = 4'd8; y_i = 4'd12; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_in_subx", int'(x_ld && x_sel), 1);
        #1 RESET = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_strobes", int'({x_sel, x_ld, y_sel, y_ld, d_ld, done, err}), 0);
        check("rst_mid_iter", int'(iter_o), 0);
        @(negedge CLK);
        RESET = 1'b1;
        do_run(4'd8, 4'd12, 1'b0, 100, dc, it, dv, ev, dn, dcy, sc, lo);
        check("rst_rerun_d", dv, 4);
        check("rst_rerun_cyc", dc, 8);

        // Zero operand
`ifdef GCD_TIMEOUT_EN
        do_run(4'd0, 4'd5, 1'b0, 100, dc, it, dv, ev, dn, dcy, sc, lo);
        check("wd_done_cyc", dc, 35);
        check("wd_err", ev, 1);
        check("wd_iter", it, MAX_ITER);
        check("wd_no_dld", dn, 0);
        @(negedge CLK);
        check("wd_idle", int'(busy), 0);
`else
        @(negedge CLK);
        x_i = 4'd0; y_i = 4'd5; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        dn = 0;
        for (int c = 0; c < 80; c++) begin
            if (done || err || d_ld) dn++;
            @(negedge CLK);
        end
        check("hang_no_done", dn, 0);
        check("hang_busy", int'(busy), 1);
        check("hang_iter_sat", int'(iter_o), (1 << ITER_W) - 1);
        RESET = 1'b0;
        #1;
        check("hang_reset_iter", int'(iter_o), 0);
        check("hang_reset_busy", int'(busy), 0);
        @(negedge CLK);
        RESET = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : timeout_guard
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
